// File: rtl/psum_round_scheduler_if.sv
// Purpose : bundles the PE-side request bus and the router-side result bus
//           of the partial-sum round scheduler.
// Signals : pe_valid/pe_ready/pe_packet - one psum packet per PE per round
//           out_valid/out_ready/out_packet - routed result packet
//           round_done - pulse when a result is accepted
//           addr_err   - sticky psum address mismatch flag
// Modports: master = PE/router side, slave = scheduler side.
interface psum_round_scheduler_if #(
    parameter int unsigned NUM_PE   = 5,
    parameter int unsigned PACKET_W = 57
);
    logic [NUM_PE-1:0]          pe_valid;
    logic [NUM_PE-1:0]          pe_ready;
    logic [NUM_PE*PACKET_W-1:0] pe_packet;
    logic                       out_valid;
    logic                       out_ready;
    logic [PACKET_W-1:0]        out_packet;
    logic                       round_done;
    logic                       addr_err;

    modport master (
        output pe_valid, pe_packet, out_ready,
        input  pe_ready, out_valid, out_packet, round_done, addr_err
    );

    modport slave (
        input  pe_valid, pe_packet, out_ready,
        output pe_ready, out_valid, out_packet, round_done, addr_err
    );
endinterface

// File: rtl/psum_round_scheduler.sv
// Purpose : collects one psum packet from each of NUM_PE PEs in any arrival
//           order (round-robin arbitration), accumulates the psums modulo
//           2^PSUM_W and emits one routed result packet per round.
// Ports   : clk, rst_n (async, active low)
//           bus (slave modport of psum_round_scheduler_if):
//             pe_valid/pe_ready/pe_packet in, out_valid/out_packet/round_done/
//             addr_err out, out_ready in. pe_ready is combinational.
module psum_round_scheduler #(
    parameter int unsigned NUM_PE   = 5,
    parameter int unsigned PACKET_W = 57,
    parameter int unsigned PSUM_W   = 13,
    parameter int unsigned ADDR_W   = 27,
    parameter int unsigned NODE_ID  = 13,
    parameter int unsigned DEST_ID  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    psum_round_scheduler_if.slave  bus
);
    localparam int unsigned PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned BUS_W  = NUM_PE * PACKET_W;
    localparam int unsigned IDX_W  = $clog2(BUS_W);
    localparam int unsigned X_HOP  = (NODE_ID == 13) ? 2 : 1;
    localparam logic [NUM_PE-1:0] ALL_GOT = '1;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_SEND    = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_PE-1:0]   r_got_mask;
    logic [PSUM_W-1:0]   r_acc;
    logic [ADDR_W-1:0]   r_addr;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic                r_out_valid;
    logic [PACKET_W-1:0] r_out_packet;
    logic                r_round_done;
    logic                r_addr_err;

    logic [NUM_PE-1:0]   w_elig;
    logic [NUM_PE-1:0]   w_grant;
    logic [PTR_W-1:0]    w_gidx;
    logic                w_found;
    logic                w_xfer;
    logic                w_accept;
    logic                w_first;
    logic [IDX_W-1:0]    w_base;
    logic [PSUM_W-1:0]   w_sel_psum;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [PSUM_W-1:0]   w_acc_nxt;
    logic [ADDR_W-1:0]   w_addr_res;

    // (base + off) mod NUM_PE for off < NUM_PE
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PE) s = s - NUM_PE;
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first eligible PE at or after rr_ptr
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        w_elig  = (r_state == S_COLLECT) ? (bus.pe_valid & ~r_got_mask) : '0;
        for (int unsigned k = 0; k < NUM_PE; k++) begin
            if (!w_found && w_elig[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_gidx  = wrap_idx(r_rr_ptr, k);
            end
        end
        w_grant[w_gidx] = w_found;
    end

    // Fields of the granted PE's packet
    assign w_base     = IDX_W'(32'(w_gidx) * PACKET_W);
    assign w_sel_psum = bus.pe_packet[w_base +: PSUM_W];
    assign w_sel_addr = bus.pe_packet[w_base + IDX_W'(PSUM_W) +: ADDR_W];
    assign w_first    = (r_got_mask == '0);
    assign w_acc_nxt  = r_acc + w_sel_psum;
    assign w_addr_res = w_first ? w_sel_addr : r_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_COLLECT;
        else        r_state <= w_state_nxt;
    end

    // Next state: leave COLLECT on the transfer that completes the mask
    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_xfer = w_found;
                if (w_found && ((r_got_mask | w_grant) == ALL_GOT))
                    w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_COLLECT;
                end
            end
        endcase
    end

    // Round datapath; result packet is captured on the completing transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_got_mask   <= '0;
            r_acc        <= '0;
            r_addr       <= '0;
            r_rr_ptr     <= '0;
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
            r_round_done <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_round_done <= w_accept;
            if (w_xfer) begin
                r_acc      <= w_acc_nxt;
                r_got_mask <= r_got_mask | w_grant;
                r_rr_ptr   <= wrap_idx(w_gidx, 1);
                if (w_first)
                    r_addr <= w_sel_addr;
                else if (w_sel_addr != r_addr)
                    r_addr_err <= 1'b1;
                if (w_state_nxt == S_SEND) begin
                    r_out_valid  <= 1'b1;
                    r_out_packet <= PACKET_W'({1'b0, 4'(NODE_ID), 4'(DEST_ID),
                                               1'b1, 3'(X_HOP), 1'b1, 3'd0,
                                               w_addr_res, w_acc_nxt});
                end
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_got_mask  <= '0;
            end
        end
    end

    // Grants are suppressed while reset is asserted
    assign bus.pe_ready   = rst_n ? w_grant : '0;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_packet = r_out_packet;
    assign bus.round_done = r_round_done;
    assign bus.addr_err   = r_addr_err;
endmodule

// File: tb/tb_psum_round_scheduler.sv
// Purpose : self-checking bench for psum_round_scheduler; drives two
//           instances (NODE_ID 13 and 14) with identical PE traffic and
//           checks them cycle by cycle against a round-level reference model.
module tb_psum_round_scheduler;
    localparam int unsigned NUM_PE   = 5;
    localparam int unsigned PACKET_W = 57;

    typedef struct {
        logic [12:0] psum;
        logic [26:0] addr;
        int          start;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psum_round_scheduler_if #(.NUM_PE(NUM_PE), .PACKET_W(PACKET_W)) b13 ();
    psum_round_scheduler_if #(.NUM_PE(NUM_PE), .PACKET_W(PACKET_W)) b14 ();
    assign b14.pe_valid  = b13.pe_valid;
    assign b14.pe_packet = b13.pe_packet;
    assign b14.out_ready = b13.out_ready;

    psum_round_scheduler #(.NODE_ID(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(b13.slave));
    psum_round_scheduler #(.NODE_ID(14)) u14 (.clk(clk), .rst_n(rst_n), .bus(b14.slave));

    int tests = 0;
    int fails = 0;

    req_t q[NUM_PE][$];
    int   cyc;
    int   ready_pct;
    int   xfers;

    // Reference model: round contents, not cycle mechanics
    bit [NUM_PE-1:0] m_got;
    logic [12:0]     m_acc;
    logic [26:0]     m_addr;
    int              m_ptr;
    bit              m_err, m_send, m_rd;
    logic [56:0]     m_pkt13, m_pkt14;
    logic [56:0]     last13, last14;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [56:0] build(input int node, input logic [26:0] a, input logic [12:0] p);
        logic [2:0] xh;
        xh = (node == 13) ? 3'd2 : 3'd1;
        return {1'b0, 4'(node), 4'd15, 1'b1, xh, 1'b1, 3'd0, a, p};
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NUM_PE; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_got = '0; m_acc = '0; m_addr = '0; m_ptr = 0;
        m_err = 0; m_send = 0; m_rd = 0;
        for (int i = 0; i < NUM_PE; i++) q[i].delete();
    endtask

    task automatic push(input int pe, input logic [12:0] p, input logic [26:0] a, input int st);
        req_t r;
        r.psum = p; r.addr = a; r.start = st;
        q[pe].push_back(r);
    endtask

    task automatic drive_inputs();
        logic [NUM_PE-1:0]          v;
        logic [NUM_PE*PACKET_W-1:0] pk;
        v = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            pk[i*PACKET_W +: PACKET_W] = PACKET_W'({$urandom(), $urandom()});
            if (q[i].size() > 0 && q[i][0].start <= cyc) begin
                v[i] = 1'b1;
                pk[i*PACKET_W +: PACKET_W] = {1'b0, 4'(i), 4'd13, 8'h00, q[i][0].addr, q[i][0].psum};
            end
        end
        b13.pe_valid  = v;
        b13.pe_packet = pk;
        b13.out_ready = ($urandom_range(99) < ready_pct);
    endtask

    // One clock: check outputs mid-cycle, advance model, drive next inputs
    task automatic step();
        int                g;
        logic [NUM_PE-1:0] exp_rdy;
        req_t              r;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (!m_send)
            for (int k = 0; k < NUM_PE; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_PE;
                if (g < 0 && b13.pe_valid[idx] && !m_got[idx]) g = idx;
            end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("pe_ready13", b13.pe_ready, exp_rdy);
        chk("pe_ready14", b14.pe_ready, exp_rdy);
        chk("out_valid13", b13.out_valid, m_send);
        chk("out_valid14", b14.out_valid, m_send);
        if (m_send) begin
            chk("out_packet13", b13.out_packet, m_pkt13);
            chk("out_packet14", b14.out_packet, m_pkt14);
        end
        chk("round_done", b13.round_done, m_rd);
        chk("addr_err", b13.addr_err, m_err);
        m_rd = 0;
        if (g >= 0) begin
            r = q[g].pop_front();
            m_acc = m_acc + r.psum;
            if (m_got == '0) m_addr = r.addr;
            else if (r.addr != m_addr) m_err = 1;
            m_got[g] = 1'b1;
            m_ptr = (g + 1) % NUM_PE;
            xfers++;
            if (&m_got) begin
                m_send  = 1;
                m_pkt13 = build(13, m_addr, m_acc);
                m_pkt14 = build(14, m_addr, m_acc);
            end
        end else if (m_send && b13.out_ready) begin
            last13 = b13.out_packet;
            last14 = b14.out_packet;
            m_send = 0; m_got = '0; m_acc = '0; m_rd = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic run_idle(input int max_cyc);
        int n;
        n = 0;
        drive_inputs();
        while ((pending() || m_send) && n < max_cyc) begin
            step();
            n++;
        end
        if (pending() || m_send) begin
            tests++; fails++;
            $error("FAIL timeout: round still open after %0d cycles, expected idle", n);
        end
        step();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready13"}, b13.pe_ready, 0);
        chk({tag, "_ready14"}, b14.pe_ready, 0);
        chk({tag, "_valid13"}, b13.out_valid, 0);
        chk({tag, "_valid14"}, b14.out_valid, 0);
        chk({tag, "_pkt13"}, b13.out_packet, 0);
        chk({tag, "_pkt14"}, b14.out_packet, 0);
        chk({tag, "_done"}, b13.round_done, 0);
        chk({tag, "_err13"}, b13.addr_err, 0);
        chk({tag, "_err14"}, b14.addr_err, 0);
    endtask

    initial begin
        logic [12:0] sum;
        logic [12:0] p;
        int          n;
        int          base_x;
        cyc = 0; xfers = 0; ready_pct = 100;
        model_reset();
        push(0, 13'd1, 27'd7, 0);
        drive_inputs();
        #12;
        chk_idle_outputs("reset");
        model_reset();
        drive_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T1: in-order, all valid at once
        for (int i = 0; i < NUM_PE; i++) push(i, 13'(i + 1), 27'd7, cyc);
        run_idle(40);
        chk("t1_psum", last13[12:0], 15);
        chk("t1_addr", last13[39:13], 7);
        chk("t1_src", last13[55:52], 13);
        chk("t1_dest", last13[51:48], 15);
        chk("t1_xhop", last13[46:44], 2);

        // T2: staggered out-of-order arrival
        push(3, 13'd10, 27'd7, cyc);     push(0, 13'd20, 27'd7, cyc + 2);
        push(4, 13'd30, 27'd7, cyc + 4); push(1, 13'd40, 27'd7, cyc + 6);
        push(2, 13'd50, 27'd7, cyc + 8);
        run_idle(60);
        chk("t2_psum", last13[12:0], 150);

        // T3: PE1 holds a second packet across the round boundary
        sum = '0;
        for (int i = 0; i < NUM_PE; i++) push(i, 13'(100 + i), 27'd7, cyc);
        push(1, 13'd99, 27'd7, cyc);
        for (int i = 0; i < NUM_PE; i++) if (i != 1) push(i, 13'd1, 27'd7, cyc + 10);
        run_idle(80);
        chk("t3_psum", last13[12:0], 13'd99 + 13'd4);

        // T4: wrap-around sum under back-pressure
        ready_pct = 0;
        for (int i = 0; i < NUM_PE; i++) push(i, 13'h1FFF, 27'd7, cyc);
        drive_inputs();
        n = 0;
        while (!m_send && n < 20) begin step(); n++; end
        repeat (10) step();
        ready_pct = 100;
        run_idle(20);
        chk("t4_psum", last13[12:0], 13'h1FFB);

        // T5: address mismatch from a late PE2
        for (int i = 0; i < NUM_PE; i++)
            if (i != 2) push(i, 13'd5, 27'd7, cyc);
        push(2, 13'd5, 27'd9, cyc + 3);
        run_idle(40);
        chk("t5_err", b13.addr_err, 1);
        chk("t5_addr", last13[39:13], 7);
        for (int i = 0; i < NUM_PE; i++) push(i, 13'd2, 27'd7, cyc);
        run_idle(40);
        chk("t5_err_sticky", b13.addr_err, 1);

        // T6: reset after three transfers, then a fresh round
        for (int i = 0; i < NUM_PE; i++) push(i, 13'h0AA, 27'd3, cyc);
        base_x = xfers;
        drive_inputs();
        n = 0;
        while (xfers < base_x + 3 && n < 20) begin step(); n++; end
        rst_n = 1'b0;
        #2;
        chk_idle_outputs("t6_rst");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        sum = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            p = 13'(3 * i + 1);
            sum = sum + p;
            push(i, p, 27'd11, cyc);
        end
        run_idle(40);
        chk("t6_psum", last13[12:0], sum);
        chk("t6_addr", last13[39:13], 11);
        chk("t6_xhop14", last14[46:44], 1);
        chk("t6_src14", last14[55:52], 14);

        // Randomised rounds: random values, arrival order and back-pressure
        ready_pct = 60;
        for (int r = 0; r < 25; r++) begin
            logic [26:0] a;
            a = 27'($urandom);
            for (int i = 0; i < NUM_PE; i++)
                push(i, 13'($urandom), ($urandom_range(9) == 0) ? 27'($urandom) : a,
                     cyc + int'($urandom_range(6)));
            run_idle(120);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
